sram_bus_arbiter: RTL

- Shares one like-SRAM memory port between the instruction-fetch requester (IF stage) and the data requester (EXE/MEM stages).
- Sits between mycpu_top's stage logic and the single memory/AXI bridge port.
- Grants one address-phase request per cycle; data requester wins by default; an anti-starvation counter protects fetch.
- Tracks outstanding requests in an owner FIFO and routes each in-order response back to the requester that issued it.

---
 rtl/sram_bus_arbiter_pkg.sv | 15 +
 rtl/sram_bus_arbiter_owner_fifo.sv | 47 ++++
 rtl/sram_bus_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared owner tags, size encodings and default depths for the
// instruction/data SRAM-like bus arbiter.
package sram_bus_arbiter_pkg;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int DEF_MAX_OUTST  = 4;
    localparam int DEF_STARVE_LIM = 4;

endpackage

// File: rtl/sram_bus_arbiter_owner_fifo.sv
// Owner FIFO: one bit per accepted request, popped in order as
// responses return so each response reaches the requester that issued it.
module arb_owner_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like memory port between fetch and data requesters,
// data first with an anti-starvation limit for fetch.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_OUTST  = DEF_MAX_OUTST,
    parameter int STARVE_LIM = DEF_STARVE_LIM
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_req,
    input  logic                inst_wr,
    input  logic [1:0]          inst_size,
    input  logic [DATA_W/8-1:0] inst_wstrb,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [DATA_W-1:0]   inst_wdata,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [1:0]          mem_size,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                resp_err
);

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] LIM = STARVE_LIM[SW-1:0];

    logic          lock_valid_q, lock_owner_q;
    logic [SW-1:0] starve_q;
    logic          resp_err_q;

    logic granted, owner, hs, pop;
    logic full, empty, head;

    always_comb begin
        granted = 1'b0;
        owner   = OWN_DATA;
        if (!full) begin
            if (lock_valid_q) begin
                granted = 1'b1;
                owner   = lock_owner_q;
            end else if (data_req && !(inst_req && starve_q == LIM)) begin
                granted = 1'b1;
                owner   = OWN_DATA;
            end else if (inst_req) begin
                granted = 1'b1;
                owner   = OWN_INST;
            end
        end
    end

    assign mem_req   = granted;
    assign mem_wr    = (owner == OWN_DATA) ? data_wr    : inst_wr;
    assign mem_size  = (owner == OWN_DATA) ? data_size  : inst_size;
    assign mem_wstrb = (owner == OWN_DATA) ? data_wstrb : inst_wstrb;
    assign mem_addr  = (owner == OWN_DATA) ? data_addr  : inst_addr;
    assign mem_wdata = (owner == OWN_DATA) ? data_wdata : inst_wdata;

    assign hs           = mem_req & mem_addr_ok;
    assign inst_addr_ok = hs & (owner == OWN_INST);
    assign data_addr_ok = hs & (owner == OWN_DATA);

    assign pop          = mem_data_ok & ~empty;
    assign inst_data_ok = pop & (head == OWN_INST);
    assign data_data_ok = pop & (head == OWN_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign resp_err     = resp_err_q;

    arb_owner_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (hs),
        .din_i   (owner),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid_q <= 1'b0;
            lock_owner_q <= OWN_INST;
            starve_q     <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            // Hold the chosen owner until memory takes it.
            if (mem_req && !mem_addr_ok) begin
                lock_valid_q <= 1'b1;
                lock_owner_q <= owner;
            end else if (hs) begin
                lock_valid_q <= 1'b0;
            end
            if (!inst_req || (hs && owner == OWN_INST))
                starve_q <= '0;
            else if (hs && starve_q != LIM)
                starve_q <= starve_q + 1'b1;
            if (mem_data_ok && empty)
                resp_err_q <= 1'b1;
        end
    end

endmodule
